// File: rtl/pwm_demod_if.sv
// Handshake-free sample bus between the PWM demodulator and its consumer.
`timescale 1ns/1ps
interface pwm_demod_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             din;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             locked;
  logic             overflow;

  modport master (
    output en, din,
    input  sample, sample_valid, locked, overflow
  );

  modport slave (
    input  en, din,
    output sample, sample_valid, locked, overflow
  );
endinterface

// File: rtl/pwm_demod.sv
// PWM demodulator: counts din high cycles over a PERIOD window aligned to a rising edge; PWM_DEMOD_AVG_EN averages two windows.
// Latency: SYNC_STAGES cycles din to ds, 1 cycle last window bit to sample_valid; no backpressure, the strobe is fire-and-forget.
`timescale 1ns/1ps
module pwm_demod #(
  parameter int PERIOD      = 256,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_100,
  input  logic        rst,
  pwm_demod_if.slave  bus
);
  localparam int CW = $clog2(PERIOD + 1);
  localparam int XW = (CW > WIDTH) ? CW : WIDTH;
  localparam logic [XW-1:0] MAXV = XW'({WIDTH{1'b1}});

  typedef enum logic [1:0] {IDLE, HUNT, MEASURE} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ds_d;
  logic [CW-1:0]          r_win;
  logic [CW-1:0]          r_ones;
  logic [WIDTH-1:0]       r_sample;
  logic                   r_valid;
  logic                   r_locked;
  logic                   r_ovf;
`ifdef PWM_DEMOD_AVG_EN
  logic [WIDTH-1:0]       r_prev;
  logic                   r_primed;
  logic [WIDTH:0]         w_avg_sum;
`endif

  logic                   w_ds;
  logic                   w_rise;
  logic [CW-1:0]          w_total;
  logic [XW-1:0]          w_total_x;
  logic                   w_over;
  logic [WIDTH-1:0]       w_sat;
  logic                   w_last;

  assign w_ds      = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_ds & ~r_ds_d;
  // Count including the bit of the current cycle, so the last window bit is in the total.
  assign w_total   = r_ones + CW'(w_ds);
  assign w_total_x = XW'(w_total);
  assign w_over    = (w_total_x > MAXV);
  assign w_sat     = w_over ? {WIDTH{1'b1}} : w_total_x[WIDTH-1:0];
  assign w_last    = (r_win == CW'(PERIOD - 1));
`ifdef PWM_DEMOD_AVG_EN
  assign w_avg_sum = {1'b0, w_sat} + {1'b0, r_prev} + (WIDTH+1)'(1);
`endif

  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_valid;
  assign bus.locked       = r_locked;
  assign bus.overflow     = r_ovf;

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_ds_d <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.din};
      r_ds_d <= w_ds;
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_win    <= '0;
      r_ones   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef PWM_DEMOD_AVG_EN
      r_prev   <= '0;
      r_primed <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (!bus.en) begin
        // Partial window is dropped; sample keeps its last value.
        r_state  <= IDLE;
        r_locked <= 1'b0;
        r_win    <= '0;
        r_ones   <= '0;
`ifdef PWM_DEMOD_AVG_EN
        r_primed <= 1'b0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= HUNT;
          end
          HUNT: begin
            if (w_rise) begin
              r_state  <= MEASURE;
              r_locked <= 1'b1;
              r_win    <= CW'(1);
              r_ones   <= CW'(1);
            end
          end
          MEASURE: begin
            if (w_last) begin
              r_win  <= '0;
              r_ones <= '0;
              if (w_over) r_ovf <= 1'b1;
`ifdef PWM_DEMOD_AVG_EN
              r_prev   <= w_sat;
              r_primed <= 1'b1;
              if (r_primed) begin
                r_sample <= w_avg_sum[WIDTH:1];
                r_valid  <= 1'b1;
              end
`else
              r_sample <= w_sat;
              r_valid  <= 1'b1;
`endif
            end else begin
              r_win  <= r_win + CW'(1);
              r_ones <= w_total;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod: PWM frames from a duty table plus hunt, abort, relock and async-reset sequences.
`timescale 1ns/1ps
module tb_pwm_demod;
  localparam int P  = 256;
  localparam int W  = 8;
  localparam int CK = 10;
`ifdef PWM_DEMOD_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  typedef struct {
    int high;
    int exp_single;
    int exp_avg;
    int exp_ovf;
  } vec_t;

  logic clk_100 = 1'b0;
  logic rst     = 1'b1;
  pwm_demod_if #(.WIDTH(W)) bus();

  pwm_demod #(.PERIOD(P), .WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_100 (clk_100),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #(CK/2) clk_100 = ~clk_100;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      q_s[$];
  int      q_o[$];
  longint  q_t[$];
  bit      chk_gap  = 1'b0;
  bit      have_last = 1'b0;
  longint  t_last   = 0;
  longint  t_lock   = 0;
  vec_t    tbl[6];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk_100) begin
    if (bus.sample_valid) begin
      q_s.push_back(int'(bus.sample));
      q_o.push_back(int'(bus.overflow));
      q_t.push_back($time);
      if (chk_gap && have_last) check("strobe_gap", $time - t_last, P*CK);
      t_last    = $time;
      have_last = 1'b1;
    end
  end

  // One PWM frame: din high for the first h cycles, optional lock and en-abort checks.
  task automatic frame(input int h, input bit chk_lock, input int drop_at);
    for (int i = 0; i < P; i++) begin
      @(negedge clk_100);
      if (chk_lock && i == 0) t_lock = $time;
      if (chk_lock && i == 2) check("locked_before_lock", bus.locked, 0);
      if (chk_lock && i == 3) check("locked_after_lock", bus.locked, 1);
      if (drop_at >= 0) begin
        if (i == drop_at) begin
          check("locked_before_drop", bus.locked, 1);
          bus.en = 1'b0;
        end
        if (i == drop_at + 1) check("locked_after_drop", bus.locked, 0);
        if (i == drop_at + 5) bus.en = 1'b1;
      end
      bus.din = (i < h);
    end
  endtask

  initial begin
    int n0;
    int n1;
    int prior;
    int hunt_bad;
    int idx;

    tbl[0] = '{high: 128, exp_single: 128, exp_avg: 96,  exp_ovf: 0};
    tbl[1] = '{high: 0,   exp_single: 0,   exp_avg: 64,  exp_ovf: 0};
    tbl[2] = '{high: 200, exp_single: 200, exp_avg: 100, exp_ovf: 0};
    tbl[3] = '{high: 256, exp_single: 255, exp_avg: 228, exp_ovf: 1};
    tbl[4] = '{high: 128, exp_single: 128, exp_avg: 192, exp_ovf: 1};
    tbl[5] = '{high: 64,  exp_single: 64,  exp_avg: 96,  exp_ovf: 1};

    bus.en  = 1'b0;
    bus.din = 1'b0;
    repeat (3) @(negedge clk_100);
    check("rst_sample", bus.sample, 0);
    check("rst_valid", bus.sample_valid, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_overflow", bus.overflow, 0);
    rst    = 1'b0;
    bus.en = 1'b1;

    // din stuck low: never locks, never strobes.
    hunt_bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_100);
      if (bus.locked || bus.sample_valid) hunt_bad++;
    end
    check("hunt_locked_or_valid_cycles", hunt_bad, 0);
    check("hunt_strobes", q_s.size(), 0);
    check("hunt_sample", bus.sample, 0);

    chk_gap = 1'b1;
    frame(64, 1'b1, -1);
    foreach (tbl[k]) frame(tbl[k].high, 1'b0, -1);
    frame(128, 1'b0, 102);
    chk_gap = 1'b0;

    if (q_t.size() > 0)
      check("first_strobe_latency", q_t[0] - t_lock, (AVG ? 514 : 258) * CK);
    else
      check("first_strobe_present", 0, 1);
    if (!AVG) begin
      if (q_s.size() > 0) check("lock_frame_sample", q_s[0], 64);
      else check("lock_frame_sample_present", 0, 1);
    end
    foreach (tbl[k]) begin
      idx = AVG ? k : k + 1;
      if (idx < q_s.size()) begin
        check($sformatf("tbl%0d_sample", k), q_s[idx], AVG ? tbl[k].exp_avg : tbl[k].exp_single);
        check($sformatf("tbl%0d_overflow", k), q_o[idx], tbl[k].exp_ovf);
      end else begin
        check($sformatf("tbl%0d_present", k), 0, 1);
      end
    end
    check("strobes_before_abort", q_s.size(), AVG ? 6 : 7);

    // Aborted window produced nothing; relock frame must hold the old sample until its window closes.
    prior = AVG ? tbl[5].exp_avg : tbl[5].exp_single;
    n0 = q_s.size();
    frame(128, 1'b0, -1);
    check("abort_no_strobe", q_s.size(), n0);
    check("abort_sample_held", bus.sample, prior);
    frame(128, 1'b0, -1);
    repeat (10) @(negedge clk_100);
    check("relock_strobes", q_s.size(), n0 + (AVG ? 1 : 2));
    check("relock_sample", bus.sample, 128);
    check("overflow_sticky", bus.overflow, 1);
    check("relock_locked", bus.locked, 1);

    // Async reset between edges clears everything without waiting for a clock.
    repeat (50) @(negedge clk_100);
    @(posedge clk_100);
    #2 rst = 1'b1;
    #1;
    check("arst_sample", bus.sample, 0);
    check("arst_valid", bus.sample_valid, 0);
    check("arst_locked", bus.locked, 0);
    check("arst_overflow", bus.overflow, 0);
    @(negedge clk_100);
    rst = 1'b0;
    n1 = q_s.size();
    frame(64, 1'b0, -1);
    frame(64, 1'b0, -1);
    repeat (10) @(negedge clk_100);
    check("resume_strobes", q_s.size(), n1 + (AVG ? 1 : 2));
    check("resume_sample", bus.sample, 64);
    check("resume_overflow", bus.overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_demod.md
Name: pwm_demod

Overview:
- Receive-side counterpart of the Sine generator's 1-bit modulated output.
- Recovers a multi-bit sample by counting high cycles of the serial bit stream over a fixed window aligned to the stream's rising edges.
- Produces one sample per window with a single-cycle valid strobe.
- Used in loopback benches and on-chip self-check of the sine path.

Parameters:
- PERIOD, 256: window length in clk_100 cycles; must equal the generator's PWM frame length; >= 4.
- WIDTH, 8: sample output width; count saturates at 2^WIDTH-1.
- SYNC_STAGES, 2: synchronizer flops on din; >= 2.

Ports:
- clk_100  in  1  100 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enable; low forces IDLE.
- din  in  1  serial modulated bit stream (the generator's sine output); asynchronous to clk_100.
- sample  out  WIDTH  recovered duty count of the last completed window.
- sample_valid  out  1  one-cycle strobe when sample updates.
- locked  out  1  high while in MEASURE.
- overflow  out  1  sticky; set when a window count exceeded 2^WIDTH-1; cleared only by rst.

Behaviour:
- Reset (async, rst=1): sample=0, sample_valid=0, locked=0, overflow=0, FSM=IDLE, all counters and synchronizer flops cleared.
- din passes through SYNC_STAGES flops to give ds. Edge detect: rise = ds & ~ds_d (one extra flop).
- FSM states:
  - IDLE: locked=0. Go to HUNT when en=1.
  - HUNT: wait for rise. On rise go to MEASURE. The cycle with rise is window cycle 0 and is counted (ds=1). win_cnt=1, ones=1.
  - MEASURE: locked=1. Each cycle win_cnt++ and ones += ds.
- Window end: on the cycle where win_cnt reaches PERIOD-1 and that bit has been added:
  - sample <= min(ones_total, 2^WIDTH-1); set overflow if ones_total > 2^WIDTH-1.
  - sample_valid=1 on the following cycle, exactly one cycle.
  - The next cycle starts a new window (win_cnt=0, ones=0). The FSM stays in MEASURE; it is free-running and does not re-hunt.
- Latency: din edge to ds is SYNC_STAGES cycles. Last window bit to sample_valid is 1 cycle.
- Counter widths: win_cnt and ones are clog2(PERIOD+1) bits; no wrap inside a window.
- en deasserted in any state: go to IDLE next cycle.
  - The partial window is discarded; no sample_valid.
  - sample holds its last value.
- rst mid-window: immediate return to reset values; no strobe.
- din constant 0 in HUNT: stay in HUNT indefinitely; sample unchanged.
- din constant 0 or 1 in MEASURE: windows still complete. Constant 0 gives sample=0; constant 1 gives PERIOD, saturated.
- en rising and rise on the same cycle: transition IDLE->HUNT only; rise is ignored, so lock occurs on the next rising edge.

Optional Feature:
- Macro: PWM_DEMOD_AVG_EN.
- Defined:
  - Output is a two-window average: sample <= (cur + prev + 1) >> 1, computed on the saturated values.
  - prev resets to 0 and is reloaded on each window end.
  - The first window after entering MEASURE produces no sample_valid; it only primes prev.
  - Re-entering IDLE clears the primed flag.
- Undefined: sample is the single-window saturated count, as specified above. The prev register and primed logic are absent.

Test Plan:
- Reset then en=1, din PWM with PERIOD=256 and 64-cycle high pulse per frame -> locked=1 after the first rise plus 2 cycles. sample_valid every 256 cycles; sample=64.
- din held at 1 after lock, PERIOD=256, WIDTH=8 -> sample=255, overflow=1 and it stays 1 after din returns to 50% PWM (sample=128).
- din held at 0 from reset with en=1 -> FSM in HUNT, locked=0, sample_valid never asserts over 2000 cycles, sample=0.
- en dropped at window cycle 100 then raised again -> no sample_valid for the aborted window; locked falls next cycle; relock on the next rise; sample keeps its prior value until the new window completes.
- rst pulsed asynchronously mid-window (between clock edges) -> all outputs 0 immediately, including overflow; normal operation resumes after release.
- With PWM_DEMOD_AVG_EN, duty 64 then 128 windows -> first window gives no strobe; the second strobe gives sample=96.
